network_core: RTL and testbench
===============================

# network_core

Event-driven, time-multiplexed SNN core controller, parametrised in neuron count, synapse depth and weight width. Buffers input spike events in a FIFO and, per event, reads one synapse row holding one signed weight per neuron. Each weight is accumulated, with saturation, into that neuron's current field by read-modify-write on the neuron SRAM. On each external `tick` it sweeps every neuron through an external update datapath, writes back the result, and emits fire events through a valid/ready output with timestamps.

## Interface
- `NR_WIDTH`, 56: neuron state word width.
- `NR_DEPTH`, 16: neurons.
- `NR_I_WIDTH`, 16: signed current field, bits `[NR_I_WIDTH-1:0]` of neuron word.
- `SR_SYN_WIDTH`, 4: signed weight width.
- `SR_WIDTH`, `NR_DEPTH*SR_SYN_WIDTH`: synapse row width; weight j at `[j*SR_SYN_WIDTH +: SR_SYN_WIDTH]`.
- `SR_DEPTH`, 16384: synapse rows, indexed by input event.
- `IN_FIFO_DEPTH`, 8: input event FIFO entries, power of two.
- `MAX_NETWORK_TIME`, 65536: timesteps per run.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin run (pulse).
- `tick` in 1: end current timestep's accumulation (pulse).
- `in_valid` / `in_ready` in/out 1: input event handshake.
- `in_index` in `$clog2(SR_DEPTH)`: synapse row of event.
- `sr_addr` out `$clog2(SR_DEPTH)`, `sr_rdata` in `SR_WIDTH`: synapse SRAM, read-only.
- `nr_addr` out `$clog2(NR_DEPTH)`, `nr_we` out 1, `nr_wdata` out `NR_WIDTH`, `nr_rdata` in `NR_WIDTH`: neuron SRAM.
- `upd_neuron` out `NR_WIDTH`: word to update datapath; equals `nr_rdata`.
- `upd_result` in `NR_WIDTH`, `upd_fire` in 1: combinational update result.
- `out_valid` / `out_ready` out/in 1: fire event handshake.
- `out_index` out `$clog2(NR_DEPTH)`, `out_time` out `$clog2(MAX_NETWORK_TIME)`: fired neuron, timestep.
- `busy` out 1, `done` out 1 (one-cycle pulse), `timestep` out `$clog2(MAX_NETWORK_TIME)`, `tick_overrun` out 1 (sticky).

## Operation
- Both SRAMs: synchronous read. Address in cycle N gives data in N+1. Write happens on the clock edge when `nr_we`=1.
- States: IDLE, ACC_WAIT, ACC_ROW, ACC_RD, ACC_WR, UPD_RD, UPD_WR, STEP_END. `j` is the neuron counter.
- IDLE: `start` moves to ACC_WAIT, `timestep`=0, clears `tick_overrun`. `start` outside IDLE is ignored.
- `tick` in any ACC_* state sets `tick_pending`. `tick` in UPD_*/STEP_END sets `tick_overrun` and is otherwise dropped. `tick` in IDLE is ignored.
- ACC_WAIT, in priority order:
  - `tick_pending`: clear it, `j`=0, go to UPD_RD.
  - Else, if FIFO not empty: pop, drive `sr_addr`=head, go to ACC_ROW.
  - Else stay.
- ACC_ROW: latch `sr_rdata`, `j`=0, go to ACC_RD.
- ACC_RD: `nr_addr`=j, go to ACC_WR.
- ACC_WR:
  - `nr_we`=1, `nr_addr`=j.
  - `nr_wdata` = `nr_rdata` with current field = sat(I + sext(w_j)).
  - The sum is computed at `NR_I_WIDTH+1` bits and clamped to [-2^(NR_I_WIDTH-1), 2^(NR_I_WIDTH-1)-1]. Zero weights are still written.
  - If `j`=NR_DEPTH-1 go to ACC_WAIT, else `j`++ and go to ACC_RD.
- UPD_RD: `nr_addr`=j, go to UPD_WR.
- UPD_WR: `nr_addr` held at j.
  - Stall (no write, stay) while `upd_fire` && `out_valid` && !`out_ready`.
  - Otherwise: `nr_we`=1, `nr_wdata`=`upd_result`.
  - If `upd_fire`: load `out_valid`=1, `out_index`=j, `out_time`=`timestep`.
  - If last `j` go to STEP_END, else `j`++ and go to UPD_RD.
- STEP_END:
  - If `timestep`=MAX_NETWORK_TIME-1: `done`=1, go to IDLE. `timestep` holds.
  - Else `timestep`++, go to ACC_WAIT.
- Output register: cleared on `out_valid`&&`out_ready`. A simultaneous accept and new load leaves `out_valid`=1 with the new contents.
- FIFO:
  - `in_ready` = !full, valid in every state including IDLE.
  - Push on `in_valid`&&`in_ready`.
  - Push and pop in the same cycle are both performed.
  - When full, `in_ready` stays 0 even in a pop cycle (no bypass).
  - Order preserved. Events pushed during UPD_* wait for the next timestep.
- `busy` = state≠IDLE.
- `reset`:
  - Immediate return to IDLE.
  - FIFO empty; `tick_pending`, `tick_overrun`, `timestep`, `j` = 0.
  - All outputs 0 (`in_ready`=1).
  - SRAM contents untouched. An in-flight RMW is abandoned unwritten.

## Timing
- Per event: 2+2·NR_DEPTH cycles from pop to return to ACC_WAIT (34 for defaults).
- Per timestep update: 2·NR_DEPTH+1 cycles plus stall cycles.
- A `tick` arriving in ACC_WAIT with the FIFO empty is seen at the next edge. UPD_RD follows one cycle later.
- A `tick` mid-event takes effect after that event completes. Queued events are not drained first.
- `done` is asserted in the STEP_END cycle, and the block is in IDLE the next cycle.
- Input acceptance: 1 cycle. A pushed event is visible at the FIFO head the next cycle.

## Test plan
- Reset:
  - Assert `reset` mid-ACC_WR → next edge: IDLE, `nr_we`=0, `busy`=0, `in_ready`=1, `out_valid`=0, `timestep`=0.
  - That neuron word is unchanged.
- Accumulate:
  - Row 5, weight 3 = 4'hF, weight 0 = 4'h7; neuron 3 I=5, neuron 0 I=0. Event 5 → neuron 3 I=4, neuron 0 I=7, other fields preserved.
  - Returns to ACC_WAIT 34 cycles after pop.
- Saturation:
  - I=32765 + weight 7 → 32767.
  - I=-32768 + weight -8 (4'h8) → -32768.
- Fire and backpressure:
  - `upd_fire`=1 for neurons 2 and 9, `out_ready`=0 → first event {2, t=0} held.
  - Sweep stalls at j=9 with no write.
  - `out_ready`=1 → second event {9, 0}, sweep completes, `timestep`=1.
- FIFO:
  - While busy, push 8 events → `in_ready`=0, 9th held off.
  - Rows are processed in push order.
- Tick and end of run:
  - `tick` during UPD_WR → `tick_overrun`=1, no extra sweep.
  - With MAX_NETWORK_TIME=4, four ticks → `done` pulses once, `timestep`=3, IDLE.

Source files
------------

// File: rtl/network_core_if.sv
// Bus bundle for the SNN core: input events, synapse/neuron SRAM ports,
// update datapath hookup, fire-event output and run status.
interface network_core_if #(
  parameter int NR_WIDTH         = 56,
  parameter int NR_DEPTH         = 16,
  parameter int SR_SYN_WIDTH     = 4,
  parameter int SR_DEPTH         = 16384,
  parameter int MAX_NETWORK_TIME = 65536
);
  localparam int SR_WIDTH = NR_DEPTH * SR_SYN_WIDTH;
  localparam int SA       = $clog2(SR_DEPTH);
  localparam int NA       = $clog2(NR_DEPTH);
  localparam int TW       = $clog2(MAX_NETWORK_TIME);

  logic                start;
  logic                tick;
  logic                in_valid;
  logic                in_ready;
  logic [SA-1:0]       in_index;
  logic [SA-1:0]       sr_addr;
  logic [SR_WIDTH-1:0] sr_rdata;
  logic [NA-1:0]       nr_addr;
  logic                nr_we;
  logic [NR_WIDTH-1:0] nr_wdata;
  logic [NR_WIDTH-1:0] nr_rdata;
  logic [NR_WIDTH-1:0] upd_neuron;
  logic [NR_WIDTH-1:0] upd_result;
  logic                upd_fire;
  logic                out_valid;
  logic                out_ready;
  logic [NA-1:0]       out_index;
  logic [TW-1:0]       out_time;
  logic                busy;
  logic                done;
  logic [TW-1:0]       timestep;
  logic                tick_overrun;

  // Core side
  modport slave (
    input  start, tick, in_valid, in_index, sr_rdata, nr_rdata,
           upd_result, upd_fire, out_ready,
    output in_ready, sr_addr, nr_addr, nr_we, nr_wdata, upd_neuron,
           out_valid, out_index, out_time, busy, done, timestep, tick_overrun
  );

  // Environment side (event source, SRAMs, update datapath, event sink)
  modport master (
    output start, tick, in_valid, in_index, sr_rdata, nr_rdata,
           upd_result, upd_fire, out_ready,
    input  in_ready, sr_addr, nr_addr, nr_we, nr_wdata, upd_neuron,
           out_valid, out_index, out_time, busy, done, timestep, tick_overrun
  );
endinterface

// File: rtl/network_core.sv
// Event-driven, time-multiplexed SNN core controller. Input events are
// queued, each one accumulates a synapse row into the neuron currents with
// saturation, and every tick sweeps all neurons through the update datapath.
module network_core #(
  parameter int NR_WIDTH         = 56,
  parameter int NR_DEPTH         = 16,
  parameter int NR_I_WIDTH       = 16,
  parameter int SR_SYN_WIDTH     = 4,
  parameter int SR_WIDTH         = NR_DEPTH * SR_SYN_WIDTH,
  parameter int SR_DEPTH         = 16384,
  parameter int IN_FIFO_DEPTH    = 8,
  parameter int MAX_NETWORK_TIME = 65536
) (
  input logic           clk,
  input logic           reset,
  network_core_if.slave bus
);
  localparam int SA = $clog2(SR_DEPTH);
  localparam int NA = $clog2(NR_DEPTH);
  localparam int TW = $clog2(MAX_NETWORK_TIME);
  localparam int FA = $clog2(IN_FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ACC_WAIT, ACC_ROW, ACC_RD, ACC_WR, UPD_RD, UPD_WR, STEP_END
  } state_t;

  state_t              state_reg, state_next;
  logic [NA-1:0]       j_reg, j_next;
  logic [SR_WIDTH-1:0] row_reg, row_next;
  logic                tick_pending_reg, tick_pending_next;
  logic                tick_overrun_reg, tick_overrun_next;
  logic [TW-1:0]       timestep_reg, timestep_next;
  logic                out_valid_reg, out_valid_next;
  logic [NA-1:0]       out_index_reg, out_index_next;
  logic [TW-1:0]       out_time_reg, out_time_next;

  // Combinational strobes
  logic [SA-1:0]       sr_addr;
  logic [NA-1:0]       nr_addr;
  logic                nr_we;
  logic [NR_WIDTH-1:0] nr_wdata;
  logic                done;
  logic                pop;

  // Input event FIFO: extra pointer bit distinguishes full from empty
  logic [SA-1:0] fifo_mem [IN_FIFO_DEPTH];
  logic [FA:0]   wr_ptr_reg, rd_ptr_reg;
  logic          fifo_full, fifo_empty, push;
  logic [SA-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[FA] != rd_ptr_reg[FA]) &&
                      (wr_ptr_reg[FA-1:0] == rd_ptr_reg[FA-1:0]);
  assign push       = bus.in_valid && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_reg[FA-1:0]];

  // FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[FA-1:0]] <= bus.in_index;
  end

  // FIFO pointers; push and pop may both happen in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Split the latched synapse row into per-neuron weights
  logic [SR_SYN_WIDTH-1:0] weight [NR_DEPTH];
  genvar gi;
  generate
    for (gi = 0; gi < NR_DEPTH; gi++) begin : g_weight
      assign weight[gi] = row_reg[gi*SR_SYN_WIDTH +: SR_SYN_WIDTH];
    end
  endgenerate

  // Saturating add of the selected weight into the current field; the sum
  // carries one guard bit so overflow shows as guard != sign.
  logic [SR_SYN_WIDTH-1:0] w_sel;
  logic [NR_I_WIDTH-1:0]   cur_i, sat_i;
  logic [NR_I_WIDTH:0]     sum;
  assign w_sel = weight[j_reg];
  assign cur_i = bus.nr_rdata[NR_I_WIDTH-1:0];
  assign sum   = {cur_i[NR_I_WIDTH-1], cur_i} +
                 {{(NR_I_WIDTH+1-SR_SYN_WIDTH){w_sel[SR_SYN_WIDTH-1]}}, w_sel};
  assign sat_i = (sum[NR_I_WIDTH] == sum[NR_I_WIDTH-1]) ? sum[NR_I_WIDTH-1:0] :
                 sum[NR_I_WIDTH] ? {1'b1, {(NR_I_WIDTH-1){1'b0}}} :
                                   {1'b0, {(NR_I_WIDTH-1){1'b1}}};

  logic j_last, t_last, in_acc, in_upd, upd_stall;
  assign j_last    = (j_reg == NA'(NR_DEPTH - 1));
  assign t_last    = (timestep_reg == TW'(MAX_NETWORK_TIME - 1));
  assign in_acc    = state_reg inside {ACC_WAIT, ACC_ROW, ACC_RD, ACC_WR};
  assign in_upd    = state_reg inside {UPD_RD, UPD_WR, STEP_END};
  assign upd_stall = bus.upd_fire && out_valid_reg && !bus.out_ready;

  // Controller state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      j_reg            <= '0;
      row_reg          <= '0;
      tick_pending_reg <= 1'b0;
      tick_overrun_reg <= 1'b0;
      timestep_reg     <= '0;
      out_valid_reg    <= 1'b0;
      out_index_reg    <= '0;
      out_time_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      j_reg            <= j_next;
      row_reg          <= row_next;
      tick_pending_reg <= tick_pending_next;
      tick_overrun_reg <= tick_overrun_next;
      timestep_reg     <= timestep_next;
      out_valid_reg    <= out_valid_next;
      out_index_reg    <= out_index_next;
      out_time_reg     <= out_time_next;
    end
  end

  // Next-state logic, SRAM controls and fire-event loading
  always_comb begin
    state_next        = state_reg;
    j_next            = j_reg;
    row_next          = row_reg;
    tick_pending_next = tick_pending_reg;
    tick_overrun_next = tick_overrun_reg;
    timestep_next     = timestep_reg;
    out_valid_next    = out_valid_reg && !bus.out_ready;
    out_index_next    = out_index_reg;
    out_time_next     = out_time_reg;
    pop               = 1'b0;
    sr_addr           = '0;
    nr_addr           = '0;
    nr_we             = 1'b0;
    nr_wdata          = '0;
    done              = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next        = ACC_WAIT;
          timestep_next     = '0;
          tick_overrun_next = 1'b0;
          tick_pending_next = 1'b0;
        end
      end
      ACC_WAIT: begin
        if (tick_pending_reg) begin
          tick_pending_next = 1'b0;
          j_next            = '0;
          state_next        = UPD_RD;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          sr_addr    = fifo_head;
          state_next = ACC_ROW;
        end
      end
      ACC_ROW: begin
        row_next   = bus.sr_rdata;
        j_next     = '0;
        state_next = ACC_RD;
      end
      ACC_RD: begin
        nr_addr    = j_reg;
        state_next = ACC_WR;
      end
      ACC_WR: begin
        nr_we    = 1'b1;
        nr_addr  = j_reg;
        nr_wdata = {bus.nr_rdata[NR_WIDTH-1:NR_I_WIDTH], sat_i};
        if (j_last) begin
          state_next = ACC_WAIT;
        end else begin
          j_next     = j_reg + 1'b1;
          state_next = ACC_RD;
        end
      end
      UPD_RD: begin
        nr_addr    = j_reg;
        state_next = UPD_WR;
      end
      UPD_WR: begin
        nr_addr = j_reg;
        if (!upd_stall) begin
          nr_we    = 1'b1;
          nr_wdata = bus.upd_result;
          if (bus.upd_fire) begin
            out_valid_next = 1'b1;
            out_index_next = j_reg;
            out_time_next  = timestep_reg;
          end
          if (j_last) begin
            state_next = STEP_END;
          end else begin
            j_next     = j_reg + 1'b1;
            state_next = UPD_RD;
          end
        end
      end
      STEP_END: begin
        if (t_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          timestep_next = timestep_reg + 1'b1;
          state_next    = ACC_WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
    // A tick during accumulation is deferred; during the sweep it is lost
    if (bus.tick && in_acc) tick_pending_next = 1'b1;
    if (bus.tick && in_upd) tick_overrun_next = 1'b1;
  end

  assign bus.in_ready     = !fifo_full;
  assign bus.sr_addr      = sr_addr;
  assign bus.nr_addr      = nr_addr;
  assign bus.nr_we        = nr_we;
  assign bus.nr_wdata     = nr_wdata;
  assign bus.upd_neuron   = bus.nr_rdata;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_index    = out_index_reg;
  assign bus.out_time     = out_time_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = done;
  assign bus.timestep     = timestep_reg;
  assign bus.tick_overrun = tick_overrun_reg;
endmodule

// File: tb/tb_network_core.sv
// Directed bench for network_core: SRAM models, a toy update datapath
// (bumps bits [55:48], fires when bit 47 is set) and table-driven checks.
module tb_network_core;
  localparam int NR_WIDTH         = 56;
  localparam int NR_DEPTH         = 16;
  localparam int NR_I_WIDTH       = 16;
  localparam int SR_SYN_WIDTH     = 4;
  localparam int SR_WIDTH         = 64;
  localparam int SR_DEPTH         = 64;
  localparam int IN_FIFO_DEPTH    = 8;
  localparam int MAX_NETWORK_TIME = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  network_core_if #(.NR_WIDTH(NR_WIDTH), .NR_DEPTH(NR_DEPTH),
    .SR_SYN_WIDTH(SR_SYN_WIDTH), .SR_DEPTH(SR_DEPTH),
    .MAX_NETWORK_TIME(MAX_NETWORK_TIME)) bus ();

  network_core #(.NR_WIDTH(NR_WIDTH), .NR_DEPTH(NR_DEPTH),
    .NR_I_WIDTH(NR_I_WIDTH), .SR_SYN_WIDTH(SR_SYN_WIDTH), .SR_WIDTH(SR_WIDTH),
    .SR_DEPTH(SR_DEPTH), .IN_FIFO_DEPTH(IN_FIFO_DEPTH),
    .MAX_NETWORK_TIME(MAX_NETWORK_TIME)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  // SRAM models with registered read; a preload port fills neuron memory
  logic [SR_WIDTH-1:0] sr_mem [SR_DEPTH];
  logic [NR_WIDTH-1:0] nr_mem [NR_DEPTH];
  logic                pl_we   = 1'b0;
  logic [3:0]          pl_addr = '0;
  logic [NR_WIDTH-1:0] pl_data = '0;
  always @(posedge clk) begin
    bus.sr_rdata <= sr_mem[bus.sr_addr];
    bus.nr_rdata <= nr_mem[bus.nr_addr];
    if (bus.nr_we) nr_mem[bus.nr_addr] <= bus.nr_wdata;
    else if (pl_we) nr_mem[pl_addr] <= pl_data;
  end

  assign bus.upd_result = {bus.upd_neuron[55:48] + 8'd1, bus.upd_neuron[47:0]};
  assign bus.upd_fire   = bus.upd_neuron[47];

  // Monitors: pops (nonzero sr_addr), accepted fire events, done pulses
  int cyc = 0;
  int pop_addr[$];
  int pop_cyc[$];
  int fire_log[$];
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.sr_addr != 0) begin
        pop_addr.push_back(int'(bus.sr_addr));
        pop_cyc.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready)
        fire_log.push_back(int'(bus.out_index) * 100 + int'(bus.out_time));
      if (bus.done) done_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
  endtask

  function automatic logic [31:0] upper(input int n);
    return ((n == 2 || n == 9) ? 32'h8000_0000 : 32'h3C0D_0000) | 32'(n);
  endfunction

  typedef struct {
    int          n;
    logic [15:0] i_init;
    logic [3:0]  w;
    logic [15:0] i_exp;
  } acc_vec_t;
  acc_vec_t vec [16];

  initial begin
    int  acc_cnt;
    logic last_ready;
    logic seen;
    logic [NR_WIDTH-1:0] snap;
    logic [SR_WIDTH-1:0] row;

    bus.start = 0; bus.tick = 0; bus.in_valid = 0; bus.in_index = '0;
    bus.out_ready = 0;

    vec[0]  = '{0,  16'h0000, 4'h7, 16'h0007};
    vec[1]  = '{1,  16'h7FFD, 4'h7, 16'h7FFF};
    vec[2]  = '{2,  16'h8000, 4'h8, 16'h8000};
    vec[3]  = '{3,  16'h0005, 4'hF, 16'h0004};
    vec[4]  = '{4,  16'h7FFF, 4'h0, 16'h7FFF};
    vec[5]  = '{5,  16'hFFFF, 4'h1, 16'h0000};
    vec[6]  = '{6,  16'h8001, 4'hF, 16'h8000};
    vec[7]  = '{7,  16'h7FF8, 4'h7, 16'h7FFF};
    vec[8]  = '{8,  16'h0064, 4'h8, 16'h005C};
    vec[9]  = '{9,  16'h1234, 4'h0, 16'h1234};
    vec[10] = '{10, 16'h8003, 4'h8, 16'h8000};
    vec[11] = '{11, 16'h7FF9, 4'h6, 16'h7FFF};
    vec[12] = '{12, 16'hFFF8, 4'h7, 16'hFFFF};
    vec[13] = '{13, 16'h0000, 4'h8, 16'hFFF8};
    vec[14] = '{14, 16'h4000, 4'h3, 16'h4003};
    vec[15] = '{15, 16'hC000, 4'hC, 16'hBFFC};

    for (int r = 0; r < SR_DEPTH; r++) sr_mem[r] = '0;
    row = '0;
    for (int k = 0; k < 16; k++) row[vec[k].n*4 +: 4] = vec[k].w;
    sr_mem[5] = row;
    sr_mem[7] = 64'h1111_1111_1111_1111;

    // Preload neuron words while the core is held in reset
    step(1);
    for (int k = 0; k < 16; k++) begin
      pl_we = 1'b1;
      pl_addr = 4'(vec[k].n);
      pl_data = {8'h00, upper(vec[k].n), vec[k].i_init};
      step(1);
    end
    pl_we = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_nr_we", bus.nr_we, 0);
    check("rst_timestep", bus.timestep, 0);
    check("rst_overrun", bus.tick_overrun, 0);
    reset = 1'b0;
    step(2);

    // Two events queued in IDLE, then start: row 5 accumulates, row 6 is all zero
    bus.in_valid = 1; bus.in_index = 6'd5; step(1);
    bus.in_index = 6'd6; step(1);
    bus.in_valid = 0;
    bus.start = 1; step(1); bus.start = 0;
    for (int k = 0; k < 200 && pop_addr.size() < 2; k++) step(1);
    check("pop_timeout", pop_addr.size() >= 2, 1);
    if (pop_addr.size() >= 2) begin
      check("pop0_row", pop_addr[0], 5);
      check("pop1_row", pop_addr[1], 6);
      check("event_cycles", pop_cyc[1] - pop_cyc[0], 34);
    end
    step(40);
    for (int k = 0; k < 16; k++)
      check($sformatf("acc_n%0d", vec[k].n), nr_mem[vec[k].n],
            {8'h00, upper(vec[k].n), vec[k].i_exp});

    // First sweep with backpressure: neurons 2 and 9 fire
    pulse_tick();
    for (int k = 0; k < 100 && !bus.out_valid; k++) step(1);
    check("fire1_valid", bus.out_valid, 1);
    check("fire1_index", bus.out_index, 2);
    check("fire1_time", bus.out_time, 0);
    step(30);
    check("stall_nr_we", bus.nr_we, 0);
    check("stall_nr_addr", bus.nr_addr, 9);
    check("stall_timestep", bus.timestep, 0);
    check("stall_n9_unwritten", nr_mem[9][55:48], 0);
    check("stall_n8_written", nr_mem[8][55:48], 1);
    bus.out_ready = 1;
    for (int k = 0; k < 100 && bus.timestep != 1; k++) step(1);
    check("sweep1_timestep", bus.timestep, 1);
    step(3);
    check("fire_log_size", fire_log.size(), 2);
    check("fire_log0", (fire_log.size() > 0) ? fire_log[0] : -1, 200);
    check("fire_log1", (fire_log.size() > 1) ? fire_log[1] : -1, 900);

    // Fill the FIFO during the sweep; the ninth push must be held off
    pulse_tick();
    step(3);
    acc_cnt = 0;
    last_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1;
      bus.in_index = 6'(1 + acc_cnt);
      @(negedge clk);
      last_ready = bus.in_ready;
      if (last_ready) acc_cnt++;
      step(1);
    end
    bus.in_valid = 0;
    check("fifo_accepted", acc_cnt, 8);
    check("fifo_full_ready", last_ready, 0);
    check("fifo_still_sweep_t", bus.timestep, 1);
    for (int k = 0; k < 100 && bus.timestep != 2; k++) step(1);
    check("sweep2_timestep", bus.timestep, 2);
    for (int k = 0; k < 400 && pop_addr.size() < 10; k++) step(1);
    step(40);
    check("fifo_pop_count", pop_addr.size(), 10);
    for (int k = 0; k < 8; k++)
      check($sformatf("fifo_order%0d", k),
            (pop_addr.size() > 2 + k) ? pop_addr[2 + k] : -1, k + 1);

    // Tick during UPD_WR is dropped and flagged
    pulse_tick();
    step(2);
    pulse_tick();
    check("overrun_set", bus.tick_overrun, 1);
    for (int k = 0; k < 100 && bus.timestep != 3; k++) step(1);
    step(80);
    check("no_extra_sweep_t", bus.timestep, 3);
    check("no_extra_sweep_busy", bus.busy, 1);
    check("sweep_count_n0", nr_mem[0][55:48], 3);

    // Fourth tick ends the run
    pulse_tick();
    for (int k = 0; k < 100 && bus.busy; k++) step(1);
    check("end_busy", bus.busy, 0);
    check("end_timestep", bus.timestep, 3);
    check("end_done_count", done_cnt, 1);
    check("end_overrun_sticky", bus.tick_overrun, 1);
    step(5);
    check("end_done_once", done_cnt, 1);

    // Restart, then reset in the middle of an accumulate write
    bus.start = 1; step(1); bus.start = 0;
    check("restart_timestep", bus.timestep, 0);
    check("restart_overrun", bus.tick_overrun, 0);
    check("restart_busy", bus.busy, 1);
    snap = nr_mem[0];
    bus.in_valid = 1; bus.in_index = 6'd7; step(1);
    bus.in_valid = 0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.nr_we) seen = 1'b1;
    end
    check("acc_wr_reached", seen, 1);
    reset = 1'b1;
    #1;
    check("rrst_nr_we", bus.nr_we, 0);
    check("rrst_busy", bus.busy, 0);
    check("rrst_in_ready", bus.in_ready, 1);
    check("rrst_out_valid", bus.out_valid, 0);
    check("rrst_timestep", bus.timestep, 0);
    step(1);
    check("rrst_word_kept", nr_mem[0], snap);
    reset = 1'b0;
    step(3);
    check("rrst_stays_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
